// File: rtl/rfphoenix_dcache_wr_ctrl_if.sv
// Handshake/bus bundle for the dcache write controller.
//   st_*   : store-update request from the memory state machine (valid/ready)
//   fill_* : line-fill segment writes from the bus fill engine (never stalled)
//   inv    : flush of all queued stores
//   wr_*   : registered write port into the dcache data RAM
//   drop_cnt : saturating count of discarded non-qualifying stores
// The "slave" modport is the controller itself; "master" is the surrounding logic.
interface rfphoenix_dcache_wr_ctrl_if #(
    parameter int WAYS      = 4,
    parameter int SEGS      = 2,
    parameter int SEG_BYTES = 32,
    parameter int IDXW      = 7
);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int SW = (SEGS > 1) ? $clog2(SEGS) : 1;

    logic                 st_valid;
    logic                 st_ready;
    logic [6:0]           st_func;
    logic                 st_hit;
    logic [3:0]           st_acr;
    logic [WW-1:0]        st_way;
    logic [IDXW-1:0]      st_idx;
    logic [SW-1:0]        st_seg;
    logic [SEG_BYTES-1:0] st_sel;

    logic                 fill_valid;
    logic                 fill_last;
    logic [WW-1:0]        fill_way;
    logic [IDXW-1:0]      fill_idx;
    logic [SW-1:0]        fill_seg;

    logic                 inv;

    logic                 wr;
    logic [WAYS-1:0]      wr_way;
    logic [IDXW-1:0]      wr_idx;
    logic [SEGS-1:0]      wr_seg;
    logic [SEG_BYTES-1:0] wr_sel;
    logic                 wr_fill;
    logic [15:0]          drop_cnt;

    modport master (
        output st_valid, st_func, st_hit, st_acr, st_way, st_idx, st_seg, st_sel,
        output fill_valid, fill_last, fill_way, fill_idx, fill_seg, inv,
        input  st_ready, wr, wr_way, wr_idx, wr_seg, wr_sel, wr_fill, drop_cnt
    );

    modport slave (
        input  st_valid, st_func, st_hit, st_acr, st_way, st_idx, st_seg, st_sel,
        input  fill_valid, fill_last, fill_way, fill_idx, fill_seg, inv,
        output st_ready, wr, wr_way, wr_idx, wr_seg, wr_sel, wr_fill, drop_cnt
    );
endinterface

// File: rtl/rfphoenix_dcache_wr_ctrl.sv
// Data-cache write controller. Qualified store updates are queued in a small
// circular FIFO; line-fill segment writes bypass the queue with top priority.
// Both are merged onto one registered array write port with one-hot way and
// segment enables plus byte-lane enables.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : rfphoenix_dcache_wr_ctrl_if.slave (store request, fill writes,
//           flush, array write port, drop counter)
module rfphoenix_dcache_wr_ctrl #(
    parameter int         WAYS      = 4,
    parameter int         SEGS      = 2,
    parameter int         SEG_BYTES = 32,
    parameter int         IDXW      = 7,
    parameter int         QDEPTH    = 4,
    parameter logic [6:0] MR_STORE  = 7'h02,
    parameter logic [6:0] MR_MOVST  = 7'h05
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rfphoenix_dcache_wr_ctrl_if.slave bus
);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int SW = (SEGS > 1) ? $clog2(SEGS) : 1;
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FLUSH = 2'd2} state_t;

    state_t               state, state_n;
    logic                 fill_act, fill_act_n;   // a multi-segment fill is in progress
    logic [WW-1:0]        fl_way;
    logic [IDXW-1:0]      fl_idx;

    logic [WW-1:0]        q_way [QDEPTH];
    logic [IDXW-1:0]      q_idx [QDEPTH];
    logic [SW-1:0]        q_seg [QDEPTH];
    logic [SEG_BYTES-1:0] q_sel [QDEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 ready_q;

    logic                 wr_q, wr_fill_q;
    logic [WAYS-1:0]      wr_way_q;
    logic [IDXW-1:0]      wr_idx_q;
    logic [SEGS-1:0]      wr_seg_q;
    logic [SEG_BYTES-1:0] wr_sel_q;
    logic [15:0]          drop_q;

    logic accept, qualify, keep, drop, head_hit, deq;
    logic unused_acr;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign unused_acr = ^bus.st_acr[2:0];

    always_comb begin
        accept  = bus.st_valid && ready_q;
        qualify = bus.st_hit && bus.st_acr[3] && (bus.st_sel != '0) &&
                  ((bus.st_func == MR_STORE) || (bus.st_func == MR_MOVST));
        // A flush swallows a same-cycle store without counting it as a drop.
        keep    = accept && qualify && !bus.inv;
        drop    = accept && !qualify && !bus.inv;
        // Stores to the line being filled must wait until the fill completes,
        // otherwise fill data would overwrite the newer store bytes.
        head_hit = (state == FILL) && (q_idx[rd_ptr] == fl_idx) && (q_way[rd_ptr] == fl_way);
        deq      = !bus.fill_valid && !bus.inv && (cnt != '0) && !head_hit;
        fill_act_n = bus.fill_valid ? !bus.fill_last : fill_act;
        cnt_n      = bus.inv ? '0 : (cnt + CW'(keep) - CW'(deq));
        if (bus.inv)
            state_n = FLUSH;
        else if (fill_act_n)
            state_n = FILL;
        else
            state_n = IDLE;
    end

    // Control, queue pointers and registered write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            fill_act  <= 1'b0;
            fl_way    <= '0;
            fl_idx    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            ready_q   <= 1'b0;
            drop_q    <= '0;
            wr_q      <= 1'b0;
            wr_fill_q <= 1'b0;
            wr_way_q  <= '0;
            wr_idx_q  <= '0;
            wr_seg_q  <= '0;
            wr_sel_q  <= '0;
        end else begin
            state    <= state_n;
            fill_act <= fill_act_n;
            cnt      <= cnt_n;
            ready_q  <= (cnt_n != CW'(QDEPTH));
            if (bus.fill_valid && !fill_act) begin
                fl_way <= bus.fill_way;
                fl_idx <= bus.fill_idx;
            end
            if (bus.inv) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (keep) wr_ptr <= wr_ptr + PW'(1);
                if (deq)  rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop) drop_q <= sat_inc16(drop_q);

            if (bus.fill_valid) begin
                wr_q      <= 1'b1;
                wr_fill_q <= 1'b1;
                wr_way_q  <= WAYS'(1) << bus.fill_way;
                wr_idx_q  <= bus.fill_idx;
                wr_seg_q  <= SEGS'(1) << bus.fill_seg;
                wr_sel_q  <= '1;
            end else if (deq) begin
                wr_q      <= 1'b1;
                wr_fill_q <= 1'b0;
                wr_way_q  <= WAYS'(1) << q_way[rd_ptr];
                wr_idx_q  <= q_idx[rd_ptr];
                wr_seg_q  <= SEGS'(1) << q_seg[rd_ptr];
                wr_sel_q  <= q_sel[rd_ptr];
            end else begin
                wr_q      <= 1'b0;
                wr_fill_q <= 1'b0;
                wr_way_q  <= '0;
                wr_idx_q  <= '0;
                wr_seg_q  <= '0;
                wr_sel_q  <= '0;
            end
        end
    end

    // Queue storage (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (keep) begin
            q_way[wr_ptr] <= bus.st_way;
            q_idx[wr_ptr] <= bus.st_idx;
            q_seg[wr_ptr] <= bus.st_seg;
            q_sel[wr_ptr] <= bus.st_sel;
        end
    end

    assign bus.st_ready = ready_q;
    assign bus.wr       = wr_q;
    assign bus.wr_fill  = wr_fill_q;
    assign bus.wr_way   = wr_way_q;
    assign bus.wr_idx   = wr_idx_q;
    assign bus.wr_seg   = wr_seg_q;
    assign bus.wr_sel   = wr_sel_q;
    assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_rfphoenix_dcache_wr_ctrl.sv
// Scoreboard bench for rfphoenix_dcache_wr_ctrl: directed stores and fills push
// expected array writes into per-class queues; a monitor on the falling edge
// pops and compares every write the DUT presents.
module tb_rfphoenix_dcache_wr_ctrl;
    localparam int         WAYS = 4, SEGS = 2, SEG_BYTES = 32, IDXW = 7, QDEPTH = 4;
    localparam logic [6:0] MR_LOAD = 7'h01, MR_STORE = 7'h02, MR_MOVST = 7'h05;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rfphoenix_dcache_wr_ctrl_if #(.WAYS(WAYS), .SEGS(SEGS), .SEG_BYTES(SEG_BYTES), .IDXW(IDXW)) bus();

    rfphoenix_dcache_wr_ctrl #(
        .WAYS(WAYS), .SEGS(SEGS), .SEG_BYTES(SEG_BYTES), .IDXW(IDXW), .QDEPTH(QDEPTH),
        .MR_STORE(MR_STORE), .MR_MOVST(MR_MOVST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  way;
        logic [6:0]  idx;
        logic [1:0]  seg;
        logic [31:0] sel;
        int          min_f;
        int          max_f;
    } exp_t;

    exp_t exp_st[$];
    exp_t exp_fl[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   fills_seen = 0;
    int   fills_issued = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_step();
        exp_t e;
        if (bus.wr === 1'b1) begin
            if (bus.wr_fill === 1'b1) begin
                if (exp_fl.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_fill_write: got way=%b idx=%0d, required no write", bus.wr_way, bus.wr_idx);
                end else begin
                    e = exp_fl.pop_front();
                    check("fill_way", bus.wr_way, e.way);
                    check("fill_idx", bus.wr_idx, e.idx);
                    check("fill_seg", bus.wr_seg, e.seg);
                    check("fill_sel", bus.wr_sel, e.sel);
                    fills_seen++;
                end
            end else begin
                if (exp_st.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_store_write: got way=%b idx=%0d sel=%h, required no write",
                             bus.wr_way, bus.wr_idx, bus.wr_sel);
                end else begin
                    e = exp_st.pop_front();
                    check("store_way", bus.wr_way, e.way);
                    check("store_idx", bus.wr_idx, e.idx);
                    check("store_seg", bus.wr_seg, e.seg);
                    check("store_sel", bus.wr_sel, e.sel);
                    check("store_vs_fill_order", (fills_seen >= e.min_f) && (fills_seen <= e.max_f), 1);
                end
            end
        end else begin
            check("idle_outputs_zero", {bus.wr, bus.wr_way, bus.wr_idx, bus.wr_seg, bus.wr_sel, bus.wr_fill}, 64'd0);
        end
    endtask

    task automatic set_store(input logic [6:0] func, input logic hit, input logic [3:0] acr,
                             input logic [1:0] way, input logic [6:0] idx, input logic seg,
                             input logic [31:0] sel);
        bus.st_valid = 1'b1;
        bus.st_func  = func;
        bus.st_hit   = hit;
        bus.st_acr   = acr;
        bus.st_way   = way;
        bus.st_idx   = idx;
        bus.st_seg   = seg;
        bus.st_sel   = sel;
    endtask

    task automatic push_st(input logic [3:0] eway, input logic [6:0] idx, input logic [1:0] eseg,
                           input logic [31:0] sel, input int min_f, input int max_f);
        exp_t e;
        e.way = eway; e.idx = idx; e.seg = eseg; e.sel = sel; e.min_f = min_f; e.max_f = max_f;
        exp_st.push_back(e);
    endtask

    // Offer one store, hold it until accepted (bounded), then release.
    task automatic offer_store(input logic [6:0] func, input logic hit, input logic [3:0] acr,
                               input logic [1:0] way, input logic [6:0] idx, input logic seg,
                               input logic [31:0] sel, input logic keep,
                               input logic [3:0] eway, input logic [1:0] eseg,
                               input int min_f, input int max_f);
        int n = 0;
        set_store(func, hit, acr, way, idx, seg, sel);
        while (bus.st_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL store_accept_timeout: st_ready stayed %b, required 1", bus.st_ready);
        end
        if (keep) push_st(eway, idx, eseg, sel, min_f, max_f);
        tick();
        bus.st_valid = 1'b0;
    endtask

    task automatic drive_fill(input logic [1:0] way, input logic [6:0] idx, input logic seg,
                              input logic last, input logic [3:0] eway, input logic [1:0] eseg);
        exp_t e;
        bus.fill_valid = 1'b1;
        bus.fill_last  = last;
        bus.fill_way   = way;
        bus.fill_idx   = idx;
        bus.fill_seg   = seg;
        e.way = eway; e.idx = idx; e.seg = eseg; e.sel = 32'hFFFF_FFFF; e.min_f = 0; e.max_f = 0;
        exp_fl.push_back(e);
        fills_issued++;
    endtask

    task automatic end_fill();
        bus.fill_valid = 1'b0;
        bus.fill_last  = 1'b0;
    endtask

    logic [31:0] sels [5];

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sels = '{32'h0000_0001, 32'h0000_0030, 32'h0000_0500, 32'h0000_7000, 32'h0009_0000};
        rst_n = 1'b0;
        bus.st_valid = 1'b0; bus.st_func = '0; bus.st_hit = 1'b0; bus.st_acr = '0;
        bus.st_way = '0; bus.st_idx = '0; bus.st_seg = '0; bus.st_sel = '0;
        bus.fill_valid = 1'b0; bus.fill_last = 1'b0; bus.fill_way = '0; bus.fill_idx = '0;
        bus.fill_seg = '0; bus.inv = 1'b0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset state
        repeat (3) tick();
        check("rst_wr", bus.wr, 0);
        check("rst_st_ready", bus.st_ready, 0);
        check("rst_drop_cnt", bus.drop_cnt, 0);
        rst_n = 1'b1;
        check("ready_at_release", bus.st_ready, 0);
        tick();
        check("ready_after_release", bus.st_ready, 1);

        // Single qualifying store and its latency
        offer_store(MR_STORE, 1, 4'b1000, 2'd2, 7'd5, 1'b1, 32'h0000_00FF, 1, 4'b0100, 2'b10, 0, 1000);
        check("store_lat_cycle1_wr", bus.wr, 0);
        tick();
        check("store_lat_cycle2_wr", bus.wr, 1);
        repeat (2) tick();

        // Non-qualifying stores are counted, never written
        offer_store(MR_STORE, 1, 4'b0111, 2'd1, 7'd6, 1'b0, 32'h0000_0F00, 0, 4'b0, 2'b0, 0, 0);
        offer_store(MR_LOAD,  1, 4'b1000, 2'd1, 7'd6, 1'b0, 32'h0000_0F00, 0, 4'b0, 2'b0, 0, 0);
        offer_store(MR_STORE, 0, 4'b1000, 2'd1, 7'd6, 1'b0, 32'h0000_0F00, 0, 4'b0, 2'b0, 0, 0);
        repeat (3) tick();
        check("drop_cnt_after_3", bus.drop_cnt, 3);

        // Fill burst with one store to another line and one to the fill line
        drive_fill(2'd1, 7'd9, 1'b0, 1'b0, 4'b0010, 2'b01);
        set_store(MR_STORE, 1, 4'b1000, 2'd0, 7'd3, 1'b0, 32'h0000_F00F);
        push_st(4'b0001, 7'd3, 2'b01, 32'h0000_F00F, fills_issued, fills_issued);
        tick();
        end_fill();
        set_store(MR_MOVST, 1, 4'b1111, 2'd1, 7'd9, 1'b1, 32'hFFFF_0000);
        push_st(4'b0010, 7'd9, 2'b10, 32'hFFFF_0000, fills_issued + 1, 1000);
        tick();
        bus.st_valid = 1'b0;
        tick();
        tick();
        drive_fill(2'd1, 7'd9, 1'b1, 1'b1, 4'b0010, 2'b10);
        tick();
        end_fill();
        repeat (4) tick();

        // Queue fills up behind a blocking fill, then drains in order
        drive_fill(2'd2, 7'd20, 1'b0, 1'b0, 4'b0100, 2'b01);
        tick();
        end_fill();
        for (int i = 0; i < 4; i++)
            offer_store(MR_STORE, 1, 4'b1000, 2'd2, 7'd20, 1'b0, sels[i], 1, 4'b0100, 2'b01,
                        fills_issued + 1, 1000);
        check("full_st_ready", bus.st_ready, 0);
        set_store(MR_STORE, 1, 4'b1000, 2'd2, 7'd20, 1'b0, sels[4]);
        push_st(4'b0100, 7'd20, 2'b01, sels[4], fills_issued + 1, 1000);
        repeat (2) tick();
        check("full_held_st_ready", bus.st_ready, 0);
        drive_fill(2'd2, 7'd20, 1'b1, 1'b1, 4'b0100, 2'b10);
        tick();
        end_fill();
        begin
            int n = 0;
            while (bus.st_ready !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            check("fifth_store_accepted", bus.st_ready, 1);
        end
        tick();
        bus.st_valid = 1'b0;
        repeat (8) tick();

        // Flush of queued stores; a same-cycle bad store is not counted
        drive_fill(2'd3, 7'd40, 1'b0, 1'b0, 4'b1000, 2'b01);
        tick();
        end_fill();
        for (int i = 0; i < 3; i++)
            offer_store(MR_STORE, 1, 4'b1000, 2'd3, 7'd40, 1'b0, sels[i], 0, 4'b0, 2'b0, 0, 0);
        set_store(MR_STORE, 0, 4'b1000, 2'd0, 7'd1, 1'b0, 32'h1);
        bus.inv = 1'b1;
        tick();
        bus.inv = 1'b0;
        bus.st_valid = 1'b0;
        repeat (2) tick();
        check("ready_after_inv", bus.st_ready, 1);
        check("drop_cnt_inv_unchanged", bus.drop_cnt, 3);
        drive_fill(2'd3, 7'd40, 1'b1, 1'b1, 4'b1000, 2'b10);
        tick();
        end_fill();
        repeat (6) tick();

        // Reset in the middle of a fill with stores queued
        drive_fill(2'd0, 7'd50, 1'b0, 1'b0, 4'b0001, 2'b01);
        tick();
        end_fill();
        offer_store(MR_STORE, 1, 4'b1000, 2'd0, 7'd50, 1'b0, 32'h0000_00F0, 0, 4'b0, 2'b0, 0, 0);
        offer_store(MR_STORE, 1, 4'b1000, 2'd0, 7'd50, 1'b1, 32'h0000_0F00, 0, 4'b0, 2'b0, 0, 0);
        rst_n = 1'b0;
        tick();
        check("midrst_wr", bus.wr, 0);
        check("midrst_port", {bus.wr_way, bus.wr_idx, bus.wr_seg, bus.wr_sel, bus.wr_fill}, 64'd0);
        check("midrst_st_ready", bus.st_ready, 0);
        check("midrst_drop_cnt", bus.drop_cnt, 0);
        rst_n = 1'b1;
        tick();
        check("midrst_ready_after_release", bus.st_ready, 1);
        repeat (8) tick();

        check("store_queue_drained", exp_st.size(), 0);
        check("fill_queue_drained", exp_fl.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
